rc5_enc_ctrl: RTL and testbench

Iterative RC5-w/R/b encryption engine with a control FSM.
- Owns the expanded-key table S[0..2R+1], loaded through a config write port.
- Sequences one round per clock over a single shared round datapath.
- Adds valid/ready handshakes on input and output, replacing the free-running fixed-latency rc5_encryption usage.
- Sits between the block-feed logic upstream and the ciphertext sink downstream. Key expansion is done externally (software or a separate block).

---
 rtl/rc5_pkg.sv | 22 ++
 rtl/rc5_round.sv | 28 ++
 rtl/rc5_enc_ctrl.sv | 127 ++++++++++++
 tb/tb_rc5_enc_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rc5_pkg.sv
// Shared definitions for the RC5-32 engine: FSM state encoding, default
// geometry, key-schedule magic constants and a 32-bit rotate-left helper.
package rc5_pkg;

    localparam int RC5_W = 32;
    localparam int RC5_R = 12;

    localparam logic [31:0] P32 = 32'hB7E1_5163;
    localparam logic [31:0] Q32 = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } rc5_state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        if (n == 5'd0) return x;
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/rc5_round.sv
// One combinational RC5 encryption round. A' is chained straight into the
// B half so a full round completes in a single cycle.
module rc5_round #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_s_even,
    input  logic [W-1:0] i_s_odd,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b
);

    localparam int LW = $clog2(W);

    // Only the low log2(W) bits of the amount matter; zero is a pass-through.
    function automatic logic [W-1:0] rotl_w(input logic [W-1:0] x, input logic [LW-1:0] n);
        if (n == '0) return x;
        return (x << n) | (x >> (W - int'(n)));
    endfunction

    logic [W-1:0] w_a_n;

    assign w_a_n = rotl_w(i_a ^ i_b, i_b[LW-1:0]) + i_s_even;
    assign o_a   = w_a_n;
    assign o_b   = rotl_w(i_b ^ w_a_n, w_a_n[LW-1:0]) + i_s_odd;

endmodule

// File: rtl/rc5_enc_ctrl.sv
// Iterative RC5 encryptor: owns the expanded-key table, runs one round per
// clock, valid/ready on both sides. Optional RC5_BLKCNT_EN adds blk_cnt.
module rc5_enc_ctrl
    import rc5_pkg::*;
#(
    parameter int W  = RC5_W,
    parameter int R  = RC5_R,
    parameter int AW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_data,
    input  logic            sk_we,
    input  logic [AW-1:0]   sk_addr,
    input  logic [W-1:0]    sk_data,
    output logic            busy,
    output logic            sk_err
`ifdef RC5_BLKCNT_EN
    ,
    output logic [15:0]     blk_cnt
`endif
);

    localparam int NS = 2 * R + 2;
    localparam int SW = $clog2(NS);
    localparam int IW = $clog2(R + 1);

    rc5_state_t       r_state;
    rc5_state_t       w_state_n;
    logic [IW-1:0]    r_i;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [2*W-1:0]   r_out;
    logic             r_sk_err;
    logic [W-1:0]     r_s [0:NS-1];

    logic             w_accept;
    logic             w_last;
    logic             w_sk_ok;
    logic [SW-1:0]    w_ie;
    logic [SW-1:0]    w_io;
    logic [SW-1:0]    w_sk_idx;
    logic [W-1:0]     w_a_n;
    logic [W-1:0]     w_b_n;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_i == IW'(R));
    assign w_ie     = SW'({r_i, 1'b0});
    assign w_io     = SW'({r_i, 1'b1});
    assign w_sk_idx = sk_addr[SW-1:0];
    // A coinciding accept wins over a key write; out-of-range indices are refused.
    assign w_sk_ok  = sk_we && (r_state == IDLE) && !in_valid && (sk_addr <= AW'(NS - 1));

    rc5_round #(.W(W)) u_round (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_s_even (r_s[w_ie]),
        .i_s_odd  (r_s[w_io]),
        .o_a      (w_a_n),
        .o_b      (w_b_n)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_n = ROUND;
            ROUND:   if (w_last) w_state_n = DONE;
            DONE:    if (out_ready) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_i      <= '0;
            r_out    <= '0;
            r_sk_err <= 1'b0;
        end else begin
            if (sk_we && !w_sk_ok) r_sk_err <= 1'b1;
            if (w_accept) begin
                r_a <= in_data[W-1:0] + r_s[0];
                r_b <= in_data[2*W-1:W] + r_s[1];
                r_i <= IW'(1);
            end else if (r_state == ROUND) begin
                r_a <= w_a_n;
                r_b <= w_b_n;
                if (w_last) r_out <= {w_b_n, w_a_n};
                else        r_i   <= r_i + IW'(1);
            end
        end
    end

    // Key table deliberately survives reset.
    always_ff @(posedge clk) begin
        if (w_sk_ok) r_s[w_sk_idx] <= sk_data;
    end

`ifdef RC5_BLKCNT_EN
    logic [15:0] r_blk_cnt;

    always_ff @(posedge clk) begin
        if (rst)                                    r_blk_cnt <= '0;
        else if ((r_state == DONE) && out_ready)    r_blk_cnt <= r_blk_cnt + 16'd1;
    end

    assign blk_cnt = r_blk_cnt;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_out;
    assign sk_err    = r_sk_err;

endmodule

// File: tb/tb_rc5_enc_ctrl.sv
// Directed bench for rc5_enc_ctrl: latency, known RC5-32/12/16 vectors,
// back-pressure, illegal key writes and mid-block reset.
module tb_rc5_enc_ctrl;
    import rc5_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        sk_we = 1'b0;
    logic [4:0]  sk_addr = '0;
    logic [31:0] sk_data = '0;
    logic        busy;
    logic        sk_err;
`ifdef RC5_BLKCNT_EN
    logic [15:0] blk_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] s_mod [26];

    localparam logic [63:0] PT0    = 64'h0;
    localparam logic [63:0] CT_ZK  = 64'h6D8F4B15_EEDBA521;
    localparam logic [63:0] PT_K2  = 64'h6D8F4B15_EEDBA521;
    localparam logic [63:0] CT_K2  = 64'h52892B5B_AC13C0F7;

    rc5_enc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sk_we     (sk_we),
        .sk_addr   (sk_addr),
        .sk_data   (sk_data),
        .busy      (busy),
        .sk_err    (sk_err)
`ifdef RC5_BLKCNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference RC5 key schedule, little-endian key words.
    task automatic keyexp(input logic [31:0] l0, l1, l2, l3);
        logic [31:0] l [4];
        logic [31:0] a, b, t;
        int ii, jj;
        l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
        s_mod[0] = P32;
        for (int k = 1; k < 26; k++) s_mod[k] = s_mod[k-1] + Q32;
        a = '0; b = '0; ii = 0; jj = 0;
        for (int k = 0; k < 78; k++) begin
            a = rotl(s_mod[ii] + a + b, 5'd3);
            s_mod[ii] = a;
            t = a + b;
            b = rotl(l[jj] + t, t[4:0]);
            l[jj] = b;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % 4;
        end
    endtask

    task automatic sk_write(input logic [4:0] addr, input logic [31:0] data);
        sk_we = 1'b1; sk_addr = addr; sk_data = data;
        tick();
        sk_we = 1'b0;
    endtask

    task automatic load_table();
        for (int k = 0; k < 26; k++) sk_write(5'(k), s_mod[k]);
    endtask

    task automatic start_block(input logic [63:0] pt);
        in_valid = 1'b1; in_data = pt;
        tick();
        in_valid = 1'b0; in_data = {$urandom, $urandom};
    endtask

    // Waits for out_valid; returns edges counted since the accept edge.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = 0; busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic [63:0] pt, input logic [63:0] exp, input int hold);
        int lat;
        logic bok;
        start_block(pt);
        wait_done(lat, bok);
        check({tag, "_lat"}, 64'(lat), 64'd12);
        check({tag, "_busy"}, {63'd0, bok}, 64'd1);
        check({tag, "_ct"}, out_data, exp);
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vdrop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_hold"}, out_data, exp);
    endtask

    initial begin
        int lat;
        logic bok;
        logic [63:0] held;

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ovalid", {63'd0, out_valid}, 64'd0);
        check("rst_iready", {63'd0, in_ready}, 64'd1);
        check("rst_odata", out_data, 64'd0);
        check("rst_skerr", {63'd0, sk_err}, 64'd0);

        for (int k = 0; k < 26; k++) s_mod[k] = '0;
        load_table();
        run_block("zero_s", PT0, 64'd0, 0);

        keyexp(32'h0, 32'h0, 32'h0, 32'h0);
        load_table();
        run_block("zero_key", PT0, CT_ZK, 0);

        keyexp(32'h19465F91, 32'h51B241BE, 32'h01A55563, 32'h91CEA910);
        load_table();
        run_block("key2", PT_K2, CT_K2, 0);

        // Back-pressure in DONE.
        start_block(PT_K2);
        wait_done(lat, bok);
        held = out_data;
        check("bp_ct", held, CT_K2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_stable", out_data, held);
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_iready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_rel_valid", {63'd0, out_valid}, 64'd0);
        check("bp_rel_iready", {63'd0, in_ready}, 64'd1);
        start_block(PT0);
        check("bp_next_busy", {63'd0, busy}, 64'd1);
        wait_done(lat, bok);
        check("bp_next_lat", 64'(lat), 64'd12);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Illegal key writes: during ROUND, out of range, coinciding with accept.
        keyexp(32'h0, 32'h0, 32'h0, 32'h0);
        load_table();
        check("sk_clean", {63'd0, sk_err}, 64'd0);
        start_block(PT0);
        tick();
        sk_write(5'd0, 32'hDEADBEEF);
        check("sk_busy_err", {63'd0, sk_err}, 64'd1);
        wait_done(lat, bok);
        check("sk_busy_ct", out_data, CT_ZK);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        sk_write(5'd26, 32'h12345678);
        sk_write(5'd31, 32'h12345678);
        run_block("sk_range", PT0, CT_ZK, 2);
        in_valid = 1'b1; in_data = PT0;
        sk_we = 1'b1; sk_addr = 5'd1; sk_data = 32'hCAFEF00D;
        tick();
        in_valid = 1'b0; sk_we = 1'b0;
        wait_done(lat, bok);
        check("sk_coinc_ct", out_data, CT_ZK);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sk_sticky", {63'd0, sk_err}, 64'd1);

        // Reset in the middle of a block.
        start_block(PT_K2);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_ovalid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_iready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_skerr", {63'd0, sk_err}, 64'd0);
        run_block("post_rst", PT0, CT_ZK, 1);

`ifdef RC5_BLKCNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_rst", {48'd0, blk_cnt}, 64'd0);
        for (int k = 0; k < 3; k++) run_block("cnt_blk", PT0, CT_ZK, k);
        check("cnt_three", {48'd0, blk_cnt}, 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
